// File: rtl/coin_accumulator_if.sv
// ---------------------------------------------------------------------------
// coin_accumulator_if
// Groups the coin, selection, refund and dispense-request signals of the
// vending front end into one bundle.
//   master : the surroundings (coin mech, keypad, dispenser). It drives coin
//            strobes, selections, cancel and req_ready.
//   slave  : coin_accumulator. It drives the request, the credit, the refund
//            and the status pulses.
// Ports (all plain signals inside the interface):
//   coin_valid, coin_type, sel_valid, sel_product, cancel, req_ready  -> slave
//   req_valid, req_product, req_cost, credit, coin_reject, sel_short,
//   refund_valid, refund_amt, busy                                    -> master
// ---------------------------------------------------------------------------
interface coin_accumulator_if #(
    parameter int CREDIT_W = 5
);
    logic                coin_valid;
    logic                coin_type;
    logic                sel_valid;
    logic [1:0]          sel_product;
    logic                cancel;
    logic                req_ready;
    logic                req_valid;
    logic [1:0]          req_product;
    logic [CREDIT_W-1:0] req_cost;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                sel_short;
    logic                refund_valid;
    logic [CREDIT_W-1:0] refund_amt;
    logic                busy;

    modport master (
        output coin_valid, coin_type, sel_valid, sel_product, cancel, req_ready,
        input  req_valid, req_product, req_cost, credit, coin_reject, sel_short,
               refund_valid, refund_amt, busy
    );

    modport slave (
        input  coin_valid, coin_type, sel_valid, sel_product, cancel, req_ready,
        output req_valid, req_product, req_cost, credit, coin_reject, sel_short,
               refund_valid, refund_amt, busy
    );
endinterface

// File: rtl/coin_accumulator.sv
// ---------------------------------------------------------------------------
// coin_accumulator
// Vending front end: collects 5/10 unit coins into a credit total, checks a
// product selection against its price (5 * (product + 1)), and hands a single
// {product, cost} request to the dispenser over a valid/ready handshake.
// Cancel returns the credit through a one-cycle refund pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (drops credit, no refund issued)
//   bus    coin_accumulator_if.slave - coin/select/cancel inputs, request,
//          credit, refund and status outputs (all outputs registered, each
//          response appears one cycle after the input that caused it)
//
// Optional feature:
//   INACTIVITY_TIMEOUT_EN - when defined, TIMEOUT_CYCLES idle cycles in
//   COLLECT trigger an automatic refund exactly like a cancel. When
//   undefined there is no counter and COLLECT waits for a select or cancel.
// ---------------------------------------------------------------------------
module coin_accumulator #(
    parameter int CREDIT_W       = 5,
    parameter int MAX_CREDIT     = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    coin_accumulator_if.slave bus
);
    // One extra bit so credit + coin can never wrap before the ceiling check.
    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] COIN_LO_VAL = SUM_W'(32'd5);
    localparam logic [SUM_W-1:0] COIN_HI_VAL = SUM_W'(32'd10);
    localparam logic [SUM_W-1:0] MAX_VAL     = SUM_W'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REQUEST = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    // Price table: product n costs 5 * (n + 1).
    function automatic logic [SUM_W-1:0] price_of(input logic [1:0] product);
        logic [SUM_W-1:0] price;
        case (product)
            2'd0:    price = COIN_LO_VAL;
            2'd1:    price = COIN_HI_VAL;
            2'd2:    price = SUM_W'(32'd15);
            2'd3:    price = SUM_W'(32'd20);
            default: price = {SUM_W{1'b0}};
        endcase
        return price;
    endfunction

    state_t              state_r,        state_nx_s;
    logic [CREDIT_W-1:0] credit_r,       credit_nx_s;
    logic                req_valid_r,    req_valid_nx_s;
    logic [1:0]          req_product_r,  req_product_nx_s;
    logic [CREDIT_W-1:0] req_cost_r,     req_cost_nx_s;
    logic                coin_reject_r,  coin_reject_nx_s;
    logic                sel_short_r,    sel_short_nx_s;
    logic                refund_valid_r, refund_valid_nx_s;
    logic [CREDIT_W-1:0] refund_amt_r,   refund_amt_nx_s;
    logic                busy_r,         busy_nx_s;

    logic [SUM_W-1:0]    coin_value_s;
    logic [SUM_W-1:0]    coin_sum_s;
    logic                coin_fits_s;
    logic [SUM_W-1:0]    price_s;
    logic [SUM_W-1:0]    credit_eff_s;
    logic                coin_acc_s;
    logic                timeout_s;
    logic                abort_s;

    assign coin_value_s = bus.coin_type ? COIN_HI_VAL : COIN_LO_VAL;
    assign coin_sum_s   = {1'b0, credit_r} + coin_value_s;
    assign coin_fits_s  = (coin_sum_s <= MAX_VAL);
    assign price_s      = price_of(bus.sel_product);
    // Cancel and inactivity timeout end a collection the same way.
    assign abort_s      = bus.cancel | timeout_s;
    assign busy_nx_s    = (state_nx_s != ST_IDLE);

    // Next-state and next-output decode for the collection FSM.
    always_comb begin
        state_nx_s        = state_r;
        credit_nx_s       = credit_r;
        req_valid_nx_s    = req_valid_r;
        req_product_nx_s  = req_product_r;
        req_cost_nx_s     = req_cost_r;
        coin_reject_nx_s  = 1'b0;
        sel_short_nx_s    = 1'b0;
        refund_valid_nx_s = 1'b0;
        refund_amt_nx_s   = {CREDIT_W{1'b0}};
        coin_acc_s        = 1'b0;
        credit_eff_s      = {1'b0, credit_r};

        case (state_r)
            ST_IDLE: begin
                if (bus.coin_valid) begin
                    if (coin_fits_s) begin
                        coin_acc_s  = 1'b1;
                        credit_nx_s = coin_sum_s[CREDIT_W-1:0];
                        state_nx_s  = ST_COLLECT;
                    end else begin
                        coin_reject_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
                // Nothing collected yet, so any selection is short.
                if (bus.sel_valid) begin
                    sel_short_nx_s = 1'b1;
                end else begin
                    sel_short_nx_s = 1'b0;
                end
            end

            ST_COLLECT: begin
                if (abort_s) begin
                    // Cancel wins over select; a coin arriving now is bounced.
                    state_nx_s        = ST_REFUND;
                    refund_valid_nx_s = 1'b1;
                    refund_amt_nx_s   = credit_r;
                    coin_reject_nx_s  = bus.coin_valid;
                end else begin
                    if (bus.coin_valid && coin_fits_s) begin
                        coin_acc_s   = 1'b1;
                        credit_eff_s = coin_sum_s;
                    end else begin
                        coin_reject_nx_s = bus.coin_valid;
                    end
                    credit_nx_s = credit_eff_s[CREDIT_W-1:0];
                    // Price check sees the coin accepted in this same cycle.
                    if (bus.sel_valid) begin
                        if (price_s <= credit_eff_s) begin
                            state_nx_s       = ST_REQUEST;
                            req_valid_nx_s   = 1'b1;
                            req_product_nx_s = bus.sel_product;
                            req_cost_nx_s    = credit_eff_s[CREDIT_W-1:0];
                        end else begin
                            sel_short_nx_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_COLLECT;
                    end
                end
            end

            ST_REQUEST: begin
                // Request is frozen; cancel and select are ignored here.
                coin_reject_nx_s = bus.coin_valid;
                if (req_valid_r && bus.req_ready) begin
                    state_nx_s       = ST_IDLE;
                    credit_nx_s      = {CREDIT_W{1'b0}};
                    req_valid_nx_s   = 1'b0;
                    req_product_nx_s = 2'd0;
                    req_cost_nx_s    = {CREDIT_W{1'b0}};
                end else begin
                    state_nx_s = ST_REQUEST;
                end
            end

            ST_REFUND: begin
                coin_reject_nx_s = bus.coin_valid;
                credit_nx_s      = {CREDIT_W{1'b0}};
                state_nx_s       = ST_IDLE;
            end

            default: begin
                state_nx_s       = ST_IDLE;
                credit_nx_s      = {CREDIT_W{1'b0}};
                req_valid_nx_s   = 1'b0;
                req_product_nx_s = 2'd0;
                req_cost_nx_s    = {CREDIT_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            credit_r       <= {CREDIT_W{1'b0}};
            req_valid_r    <= 1'b0;
            req_product_r  <= 2'd0;
            req_cost_r     <= {CREDIT_W{1'b0}};
            coin_reject_r  <= 1'b0;
            sel_short_r    <= 1'b0;
            refund_valid_r <= 1'b0;
            refund_amt_r   <= {CREDIT_W{1'b0}};
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            credit_r       <= credit_nx_s;
            req_valid_r    <= req_valid_nx_s;
            req_product_r  <= req_product_nx_s;
            req_cost_r     <= req_cost_nx_s;
            coin_reject_r  <= coin_reject_nx_s;
            sel_short_r    <= sel_short_nx_s;
            refund_valid_r <= refund_valid_nx_s;
            refund_amt_r   <= refund_amt_nx_s;
            busy_r         <= busy_nx_s;
        end
    end

`ifdef INACTIVITY_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt_r;

    assign timeout_s = (state_r == ST_COLLECT) && (idle_cnt_r == CNT_LAST);

    // Idle counter: runs only while staying in COLLECT, cleared by activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_COLLECT) && (state_nx_s == ST_COLLECT)) begin
            if (coin_acc_s || sel_short_nx_s) begin
                idle_cnt_r <= {CNT_W{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + CNT_W'(1'b1);
            end
        end else begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end
    end
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign unused_cfg_s = (TIMEOUT_CYCLES == 32'sd0) | coin_acc_s;
`endif

    assign bus.req_valid    = req_valid_r;
    assign bus.req_product  = req_product_r;
    assign bus.req_cost     = req_cost_r;
    assign bus.credit       = credit_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.sel_short    = sel_short_r;
    assign bus.refund_valid = refund_valid_r;
    assign bus.refund_amt   = refund_amt_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_coin_accumulator.sv
// ---------------------------------------------------------------------------
// tb_coin_accumulator
// Self-checking bench for coin_accumulator. A behavioural model tracks the
// credit and mode as plain integers and predicts every output after each
// rising edge; one compare process checks all outputs every cycle. Directed
// scenarios pin the model with hand-computed values, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_coin_accumulator;
    localparam int CW   = 5;
    localparam int MAXC = 20;
    localparam int TO   = 8;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_REQUEST = 2;
    localparam int M_REFUND  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    coin_accumulator_if #(.CREDIT_W(CW)) bus ();

    coin_accumulator #(
        .CREDIT_W      (CW),
        .MAX_CREDIT    (MAXC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state and expected outputs.
    int m_mode = M_IDLE;
    int m_credit = 0;
    int m_idle = 0;
    int e_req_valid = 0, e_req_product = 0, e_req_cost = 0;
    int e_coin_reject = 0, e_sel_short = 0, e_refund_valid = 0, e_refund_amt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  v;
        int  price;
        bit  acc;
        bit  to;
        e_coin_reject  = 0;
        e_sel_short    = 0;
        e_refund_valid = 0;
        e_refund_amt   = 0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_credit = 0; m_idle = 0;
            e_req_valid = 0; e_req_product = 0; e_req_cost = 0;
        end else begin
            v     = bus.coin_type ? 10 : 5;
            price = 5 * (int'(bus.sel_product) + 1);
            case (m_mode)
                M_IDLE: begin
                    if (bus.coin_valid) begin
                        if (m_credit + v <= MAXC) begin
                            m_credit = m_credit + v; m_mode = M_COLLECT; m_idle = 0;
                        end else begin
                            e_coin_reject = 1;
                        end
                    end
                    if (bus.sel_valid) e_sel_short = 1;
                end
                M_COLLECT: begin
                    to = 0;
`ifdef INACTIVITY_TIMEOUT_EN
                    to = (m_idle == TO - 1);
`endif
                    if (bus.cancel || to) begin
                        e_refund_valid = 1; e_refund_amt = m_credit;
                        e_coin_reject = int'(bus.coin_valid); m_mode = M_REFUND;
                    end else begin
                        acc = 0;
                        if (bus.coin_valid) begin
                            if (m_credit + v <= MAXC) begin
                                m_credit = m_credit + v; acc = 1;
                            end else begin
                                e_coin_reject = 1;
                            end
                        end
                        if (bus.sel_valid) begin
                            if (price <= m_credit) begin
                                m_mode = M_REQUEST; e_req_valid = 1;
                                e_req_product = int'(bus.sel_product); e_req_cost = m_credit;
                            end else begin
                                e_sel_short = 1;
                            end
                        end
                        m_idle = (acc || e_sel_short != 0) ? 0 : m_idle + 1;
                    end
                end
                M_REQUEST: begin
                    e_coin_reject = int'(bus.coin_valid);
                    if (bus.req_ready) begin
                        m_mode = M_IDLE; m_credit = 0;
                        e_req_valid = 0; e_req_product = 0; e_req_cost = 0;
                    end
                end
                M_REFUND: begin
                    e_coin_reject = int'(bus.coin_valid);
                    m_credit = 0; m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // Compare process: advance the model on each edge, check just after it.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("req_valid",    int'(bus.req_valid),    e_req_valid);
            check("req_product",  int'(bus.req_product),  e_req_product);
            check("req_cost",     int'(bus.req_cost),     e_req_cost);
            check("credit",       int'(bus.credit),       m_credit);
            check("coin_reject",  int'(bus.coin_reject),  e_coin_reject);
            check("sel_short",    int'(bus.sel_short),    e_sel_short);
            check("refund_valid", int'(bus.refund_valid), e_refund_valid);
            check("refund_amt",   int'(bus.refund_amt),   e_refund_amt);
            check("busy",         int'(bus.busy),         (m_mode != M_IDLE) ? 1 : 0);
        end
    end

    // One clock of stimulus; strobes drop right after the edge.
    task automatic cyc(input bit coin, input bit ctype, input bit sel, input int prod,
                       input bit cancel, input bit ready);
        int p;
        p = prod;
        @(negedge clk);
        bus.coin_valid  = coin;
        bus.coin_type   = ctype;
        bus.sel_valid   = sel;
        bus.sel_product = p[1:0];
        bus.cancel      = cancel;
        bus.req_ready   = ready;
        @(posedge clk);
        #2;
        bus.coin_valid = 1'b0;
        bus.sel_valid  = 1'b0;
        bus.cancel     = 1'b0;
        bus.req_ready  = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.coin_valid  = 1'b0;
        bus.coin_type   = 1'b0;
        bus.sel_valid   = 1'b0;
        bus.sel_product = 2'd0;
        bus.cancel      = 1'b0;
        bus.req_ready   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        check("rst credit", int'(bus.credit), 0);
        check("rst req_valid", int'(bus.req_valid), 0);
        check("rst busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Coins 5, 10, select 2, then handshake.
        cyc(1, 0, 0, 0, 0, 0);  check("t1 credit5", int'(bus.credit), 5);
        check("t1 busy", int'(bus.busy), 1);
        cyc(1, 1, 0, 0, 0, 0);  check("t1 credit15", int'(bus.credit), 15);
        cyc(0, 0, 1, 2, 0, 0);  check("t1 req_valid", int'(bus.req_valid), 1);
        check("t1 product", int'(bus.req_product), 2);
        check("t1 cost", int'(bus.req_cost), 15);
        cyc(0, 0, 0, 0, 0, 1);  check("t1 credit0", int'(bus.credit), 0);
        check("t1 idle", int'(bus.busy), 0);

        // Ceiling: 10 + 10, then a 5 is rejected; select 3 costs 20.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);  check("t2 reject", int'(bus.coin_reject), 1);
        check("t2 credit20", int'(bus.credit), 20);
        cyc(0, 0, 1, 3, 0, 0);  check("t2 cost20", int'(bus.req_cost), 20);
        cyc(0, 0, 0, 0, 0, 1);

        // Short selection, then enough credit.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);  check("t3 sel_short", int'(bus.sel_short), 1);
        check("t3 busy", int'(bus.busy), 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);  check("t3 cost10", int'(bus.req_cost), 10);
        cyc(0, 0, 0, 0, 0, 1);

        // Cancel + select + coin together: refund wins, coin bounced.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0);  check("t4 refund_valid", int'(bus.refund_valid), 1);
        check("t4 refund_amt", int'(bus.refund_amt), 10);
        check("t4 reject", int'(bus.coin_reject), 1);
        check("t4 no req", int'(bus.req_valid), 0);
        idle();                 check("t4 pulse ends", int'(bus.refund_valid), 0);
        check("t4 credit0", int'(bus.credit), 0);

        // Request held without ready; cancel and coin ignored.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc((i == 2), 0, 0, 0, (i == 3), 0);
            check("t5 held valid", int'(bus.req_valid), 1);
            check("t5 held cost", int'(bus.req_cost), 10);
            check("t5 no refund", int'(bus.refund_valid), 0);
        end
        cyc(0, 0, 0, 0, 0, 1);  check("t5 released", int'(bus.req_valid), 0);

        // Asynchronous reset mid-collection clears outputs immediately.
        cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 async credit", int'(bus.credit), 0);
        check("t6 async busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Inactivity after a single coin.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            idle();
`ifdef INACTIVITY_TIMEOUT_EN
            check("t7 timeout refund", int'(bus.refund_valid), (i == TO) ? 1 : 0);
`else
            check("t7 no timeout", int'(bus.refund_valid), 0);
`endif
        end
`ifdef INACTIVITY_TIMEOUT_EN
        check("t7 back idle", int'(bus.busy), 0);
`else
        check("t7 still busy", int'(bus.busy), 1);
        check("t7 credit kept", int'(bus.credit), 5);
`endif
        cyc(0, 0, 0, 0, 1, 0);
        idle();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 99) < 15), int'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 40));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
